mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter COUNT_W, default 16: width of word_count and of the internal remaining-word counter.
REQ-002 Parameter STRIDE, default 4: byte increment applied to source and destination addresses per word.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_base  input  32  byte address of the first source word.
REQ-007 dst_base  input  32  byte address of the first destination word.
REQ-008 word_count  input  COUNT_W  number of 32-bit words to copy.
REQ-009 bus_gnt  input  1  arbiter grant of the address-decoder port; engine drives the bus only while high.
REQ-010 data_output  input  32  read data returned by the address decoder, valid one cycle after the read address.
REQ-011 bus_req  output  1  high while busy and not in DONE.
REQ-012 write_enable  output  1  write strobe to the address decoder.
REQ-013 address  output  32  byte address to the address decoder.
REQ-014 data_input  output  32  write data to the address decoder.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of a copy.
REQ-017 checksum  output  32  sum of copied words (see Configuration).

Function
REQ-018 The engine SHALL implement states IDLE, READ, WAIT, WRITE, DONE.
REQ-019 In IDLE, start=1 SHALL latch src_base, dst_base, word_count into internal registers; next state READ, or DONE if word_count=0.
REQ-020 In READ with bus_gnt=1: address=src pointer, write_enable=0; next state WAIT; with bus_gnt=0 the state SHALL hold.
REQ-021 In WAIT: data_output SHALL be captured into the data register unconditionally; next state WRITE.
REQ-022 In WRITE with bus_gnt=1: address=dst pointer, data_input=data register, write_enable=1; src and dst pointers SHALL each increment by STRIDE and the remaining count SHALL decrement; next state READ if remaining >1, else DONE; with bus_gnt=0 the state SHALL hold.
REQ-023 Per-word latency SHALL be exactly 3 cycles with continuous grant; an N-word copy SHALL assert done in cycle 3N+1 after the start cycle.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 Whenever bus_gnt=0 or state is IDLE, WAIT or DONE: write_enable=0, address=0, data_input=0.
REQ-026 start asserted while busy=1 SHALL be ignored with no effect on the copy in progress.
REQ-027 Pointer increments SHALL wrap modulo 2^32 without error indication.
REQ-028 Overlapping source and destination ranges SHALL be copied in ascending word order with no hazard correction.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and zero all outputs, pointers, counter, data register and checksum, including mid-copy; the interrupted copy SHALL NOT resume and done SHALL NOT pulse.

Configuration
REQ-030 With macro MEM_COPY_CHECKSUM_EN defined, checksum SHALL be cleared on an accepted start and SHALL add each captured word (mod 2^32) in WAIT, holding its value after DONE until the next start or reset.
REQ-031 Without MEM_COPY_CHECKSUM_EN, checksum SHALL be tied to 32'h0 and no accumulator SHALL be synthesized.

Verification
REQ-032 src_base=0x30000, dst_base=0x400, word_count=2, bus_gnt=1, data_output 0x24A then 0x999 -> writes 0x24A@0x400 and 0x999@0x404, done in cycle 7.
REQ-033 word_count=0, start pulse -> no write_enable, busy high for 1 cycle, done pulse in cycle 1.
REQ-034 bus_gnt low for 3 cycles during first WRITE, word_count=1 -> write_enable held 0 while stalled, write occurs when grant returns, done 3 cycles later than REQ-023.
REQ-035 rst_n low during READ of word 2 of 4 -> outputs zero immediately, busy=0, no done; a later start completes a fresh copy normally.
REQ-036 MEM_COPY_CHECKSUM_EN defined, words 0xFFFFFFFF and 0x2 -> checksum=0x1 at done; macro undefined -> checksum=0 throughout.
REQ-037 start pulsed during a 2-word copy -> ignored; exactly 2 writes and one done observed.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Bus port between the copy engine and the arbiter/address decoder.
// The engine uses the master modport; the decoder side uses the slave modport.
interface mem_copy_engine_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] data_input;
  logic [31:0] data_output;

  modport master (
    output bus_req,
    output write_enable,
    output address,
    output data_input,
    input  bus_gnt,
    input  data_output
  );

  modport slave (
    input  bus_req,
    input  write_enable,
    input  address,
    input  data_input,
    output bus_gnt,
    output data_output
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: read, wait one cycle for data, write, repeat.
// Optional running checksum of copied words when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned STRIDE  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         src_base,
  input  logic [31:0]         dst_base,
  input  logic [COUNT_W-1:0]  word_count,
  mem_copy_engine_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic [31:0]         checksum
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

  state_e             state_q;
  logic [31:0]        src_q;
  logic [31:0]        dst_q;
  logic [31:0]        data_q;
  logic [COUNT_W-1:0] remaining_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            src_q       <= src_base;
            dst_q       <= dst_base;
            remaining_q <= word_count;
            state_q     <= (word_count == '0) ? StDone : StRead;
          end
        end
        StRead: begin
          if (bus.bus_gnt) state_q <= StWait;
        end
        StWait: begin
          // Read data arrives one cycle after the address; grant is irrelevant here.
          data_q  <= bus.data_output;
          state_q <= StWrite;
        end
        StWrite: begin
          if (bus.bus_gnt) begin
            src_q       <= src_q + 32'(STRIDE);
            dst_q       <= dst_q + 32'(STRIDE);
            remaining_q <= remaining_q - COUNT_W'(1);
            state_q     <= (remaining_q > COUNT_W'(1)) ? StRead : StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus outputs are gated by the live grant so nothing is driven while not owning the port.
  always_comb begin
    bus.bus_req      = (state_q != StIdle) && (state_q != StDone);
    bus.write_enable = 1'b0;
    bus.address      = '0;
    bus.data_input   = '0;
    if (bus.bus_gnt) begin
      case (state_q)
        StRead:  bus.address = src_q;
        StWrite: begin
          bus.write_enable = 1'b1;
          bus.address      = dst_q;
          bus.data_input   = data_q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (state_q == StIdle && start) begin
      csum_q <= '0;
    end else if (state_q == StWait) begin
      csum_q <= csum_q + bus.data_output;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a small read-memory model.
// Checksum expectations follow MEM_COPY_CHECKSUM_EN.
module tb_mem_copy_engine;

`ifdef MEM_COPY_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  mem_copy_engine_if bus_if ();

  mem_copy_engine #(.COUNT_W(16), .STRIDE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .word_count (word_count),
    .bus        (bus_if.master),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0003_0000: return 32'h0000_024A;
      32'h0003_0004: return 32'h0000_0999;
      32'h0000_1000: return 32'hFFFF_FFFF;
      32'h0000_1004: return 32'h0000_0002;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Read data is returned one cycle after the address, as the decoder would.
  always @(posedge clk) bus_if.data_output <= mem_rd(bus_if.address);

  // Log writes and done pulses once per cycle, after any negedge stimulus has settled.
  always begin
    @(negedge clk);
    #2;
    if (bus_if.write_enable) begin
      wa.push_back(bus_if.address);
      wd.push_back(bus_if.data_input);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of cycle 1 (the cycle after start is sampled).
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src_base   = s;
    dst_base   = d;
    word_count = n;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int w0;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    src_base = '0;
    dst_base = '0;
    word_count = '0;
    bus_if.bus_gnt = 1'b1;

    // Reset state
    step(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_we", 32'(bus_if.write_enable), 32'd0);
    chk("rst_addr", bus_if.address, 32'h0);
    chk("rst_din", bus_if.data_input, 32'h0);
    chk("rst_csum", checksum, 32'h0);
    rst_n = 1'b1;

    // Two-word copy with continuous grant
    w0 = wa.size(); d0 = done_cnt;
    start_copy(32'h0003_0000, 32'h0000_0400, 16'd2);
    chk("c2_busy", 32'(busy), 32'd1);
    chk("c2_req", 32'(bus_if.bus_req), 32'd1);
    chk("c2_rd_addr", bus_if.address, 32'h0003_0000);
    chk("c2_rd_we", 32'(bus_if.write_enable), 32'd0);
    step(1);
    chk("c2_wait_addr", bus_if.address, 32'h0);
    step(1);
    chk("c2_w0_we", 32'(bus_if.write_enable), 32'd1);
    chk("c2_w0_addr", bus_if.address, 32'h0000_0400);
    chk("c2_w0_data", bus_if.data_input, 32'h0000_024A);
    step(3);
    chk("c2_w1_addr", bus_if.address, 32'h0000_0404);
    chk("c2_w1_data", bus_if.data_input, 32'h0000_0999);
    chk("c2_done_c6", 32'(done), 32'd0);
    step(1);
    chk("c2_done_c7", 32'(done), 32'd1);
    chk("c2_req_done", 32'(bus_if.bus_req), 32'd0);
    chk("c2_busy_done", 32'(busy), 32'd1);
    chk("c2_we_done", 32'(bus_if.write_enable), 32'd0);
    chk("c2_csum", checksum, CsumEn ? 32'h0000_0BE3 : 32'h0);
    step(1);
    chk("c2_busy_c8", 32'(busy), 32'd0);
    chk("c2_done_c8", 32'(done), 32'd0);
    chk("c2_nwr", 32'(wa.size() - w0), 32'd2);
    chk("c2_ndone", 32'(done_cnt - d0), 32'd1);

    // Zero-length copy
    w0 = wa.size(); d0 = done_cnt;
    start_copy(32'h0000_9000, 32'h0000_A000, 16'd0);
    chk("z_done_c1", 32'(done), 32'd1);
    chk("z_busy_c1", 32'(busy), 32'd1);
    chk("z_we_c1", 32'(bus_if.write_enable), 32'd0);
    step(1);
    chk("z_busy_c2", 32'(busy), 32'd0);
    chk("z_done_c2", 32'(done), 32'd0);
    chk("z_nwr", 32'(wa.size() - w0), 32'd0);
    chk("z_ndone", 32'(done_cnt - d0), 32'd1);

    // Grant withdrawn for three cycles during the first write
    w0 = wa.size();
    start_copy(32'h0000_2000, 32'h0000_3000, 16'd1);
    step(1);
    bus_if.bus_gnt = 1'b0;
    step(1);
    chk("st_we_c3", 32'(bus_if.write_enable), 32'd0);
    chk("st_addr_c3", bus_if.address, 32'h0);
    chk("st_busy_c3", 32'(busy), 32'd1);
    step(1);
    chk("st_we_c4", 32'(bus_if.write_enable), 32'd0);
    step(1);
    chk("st_we_c5", 32'(bus_if.write_enable), 32'd0);
    chk("st_din_c5", bus_if.data_input, 32'h0);
    step(1);
    bus_if.bus_gnt = 1'b1;
    #1;
    chk("st_we_c6", 32'(bus_if.write_enable), 32'd1);
    chk("st_addr_c6", bus_if.address, 32'h0000_3000);
    chk("st_data_c6", bus_if.data_input, 32'hA5A5_2000);
    chk("st_done_c6", 32'(done), 32'd0);
    step(1);
    chk("st_done_c7", 32'(done), 32'd1);
    step(1);
    chk("st_nwr", 32'(wa.size() - w0), 32'd1);

    // Wrapping checksum plus an ignored start during the copy
    w0 = wa.size(); d0 = done_cnt;
    start_copy(32'h0000_1000, 32'h0000_0800, 16'd2);
    step(1);
    src_base   = 32'h0003_0000;
    dst_base   = 32'h0000_0F00;
    word_count = 16'd5;
    start      = 1'b1;
    step(1);
    start = 1'b0;
    chk("ig_w0_addr", bus_if.address, 32'h0000_0800);
    chk("ig_w0_data", bus_if.data_input, 32'hFFFF_FFFF);
    step(3);
    chk("ig_w1_addr", bus_if.address, 32'h0000_0804);
    chk("ig_w1_data", bus_if.data_input, 32'h0000_0002);
    step(1);
    chk("ig_done_c7", 32'(done), 32'd1);
    chk("ck_csum_done", checksum, CsumEn ? 32'h0000_0001 : 32'h0);
    step(2);
    chk("ck_csum_hold", checksum, CsumEn ? 32'h0000_0001 : 32'h0);
    chk("ig_busy_c9", 32'(busy), 32'd0);
    chk("ig_nwr", 32'(wa.size() - w0), 32'd2);
    chk("ig_ndone", 32'(done_cnt - d0), 32'd1);

    // Reset during the read of word 2 of 4, then a fresh copy
    w0 = wa.size(); d0 = done_cnt;
    start_copy(32'h0000_5000, 32'h0000_6000, 16'd4);
    step(3);
    chk("rm_rd2_addr", bus_if.address, 32'h0000_5004);
    rst_n = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_req", 32'(bus_if.bus_req), 32'd0);
    chk("rm_addr", bus_if.address, 32'h0);
    chk("rm_done", 32'(done), 32'd0);
    chk("rm_csum", checksum, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(8);
    chk("rm_busy_after", 32'(busy), 32'd0);
    chk("rm_nwr", 32'(wa.size() - w0), 32'd1);
    chk("rm_ndone", 32'(done_cnt - d0), 32'd0);
    start_copy(32'h0003_0004, 32'h0000_0700, 16'd1);
    step(2);
    chk("rm2_addr", bus_if.address, 32'h0000_0700);
    chk("rm2_data", bus_if.data_input, 32'h0000_0999);
    step(1);
    chk("rm2_done", 32'(done), 32'd1);
    chk("rm2_csum", checksum, CsumEn ? 32'h0000_0999 : 32'h0);
    step(1);
    chk("rm2_ndone", 32'(done_cnt - d0), 32'd1);

    // Written-word log spot checks against the first copy
    chk("log_a0", wa[0], 32'h0000_0400);
    chk("log_d1", wd[1], 32'h0000_0999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
